// File: rtl/f5_sweep_ctrl.sv
// f5_sweep_ctrl: clocked sweep of f5 inputs, gate-level vs dataflow check.
// Optional: F5_STOP_ON_MISMATCH_EN ends the sweep at the first mismatch.
module f5_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_ref,
  input  logic              s_dut,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N_IN-1:0] tt,
  output logic [N_IN-1:0]   err_idx,
  output logic [N_IN:0]     err_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETL,
    S_SAMP,
    S_DONE
  } state_t;

  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic mism;
  logic last;
  logic stop;

  assign mism = s_ref ^ s_dut;
  assign last = (vec == LAST);

`ifdef F5_STOP_ON_MISMATCH_EN
  assign stop = last | mism;
`else
  assign stop = last;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_SETL;
      S_SETL: if (cnt == '0) nxt = S_SAMP;
      S_SAMP: nxt = stop ? S_DONE : S_SETL;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_SETL,
      S_SAMP: busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // pass is resolved on entry to DONE so it is valid during the done cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      vec     <= '0;
      pass    <= 1'b0;
      tt      <= '0;
      err_idx <= '0;
      err_cnt <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            vec     <= '0;
            pass    <= 1'b0;
            tt      <= '0;
            err_idx <= '0;
            err_cnt <= '0;
            cnt     <= RELOAD;
          end
        end
        S_SETL: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        S_SAMP: begin
          tt[vec] <= s_ref;
          if (mism) begin
            err_cnt <= err_cnt + (N_IN+1)'(1);
            if (err_cnt == '0) err_idx <= vec;
          end
          if (stop) begin
            pass <= (err_cnt == '0) && !mism;
          end else begin
            vec <= vec + N_IN'(1);
            cnt <= RELOAD;
          end
        end
        S_DONE: begin
          pass <= (err_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// tb_f5_sweep_ctrl: directed checks of the f5 sweep controller.
// Expectations follow F5_STOP_ON_MISMATCH_EN when it is defined.
module tb_f5_sweep_ctrl;

  logic clk = 1'b0;
  logic reset, start, start3;
  int   mode;

  logic [1:0] vec, vec3, ei, ei3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [3:0] tt, tt3;
  logic [2:0] ec, ec3;
  logic       s_ref, s_dut, s_ref3, s_dut3;

  int n_run, n_fail;

  always #5 clk = ~clk;

  // f5 models: a = vec[1], b = vec[0]; mode 1 swaps in a & ~b
  assign s_ref  = ~vec[1] & vec[0];
  assign s_dut  = (mode == 1) ? (vec[1] & ~vec[0]) : (~vec[1] & vec[0]);
  assign s_ref3 = ~vec3[1] & vec3[0];
  assign s_dut3 = ~vec3[1] & vec3[0];

  f5_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .s_ref(s_ref), .s_dut(s_dut),
    .vec(vec), .busy(busy), .done(done), .pass(pass),
    .tt(tt), .err_idx(ei), .err_cnt(ec)
  );

  f5_sweep_ctrl #(.N_IN(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .s_ref(s_ref3), .s_dut(s_dut3),
    .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .tt(tt3), .err_idx(ei3), .err_cnt(ec3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pulse start, return edge count to done (-1 on timeout) and pass after capture
  task automatic sweep(input int repulse, output int cyc, output logic p0);
    cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p0 = pass;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      start = (n == repulse);
      if (done) begin
        cyc = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int   c;
    int   nd;
    logic p0;
    n_run  = 0;
    n_fail = 0;
    mode   = 0;
    start  = 1'b0;
    start3 = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vec",  32'(vec),  0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_tt",   32'(tt),   0);
    chk("rst_eidx", 32'(ei),   0);
    chk("rst_ecnt", 32'(ec),   0);
    chk("rst_vec3", 32'(vec3), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // clean sweep
    sweep(0, c, p0);
    chk("ok_cyc",  32'(c),    8);
    chk("ok_tt",   32'(tt),   4'b0010);
    chk("ok_pass", 32'(pass), 1);
    chk("ok_ecnt", 32'(ec),   0);
    chk("ok_eidx", 32'(ei),   0);
    chk("ok_busy", 32'(busy), 0);
    chk("ok_vec",  32'(vec),  3);
    @(posedge clk); #1;
    chk("ok_done_clr", 32'(done), 0);
    chk("ok_pass_hold", 32'(pass), 1);
    chk("ok_tt_hold", 32'(tt), 4'b0010);

    // back-to-back: start in the idle cycle after done
    sweep(0, c, p0);
    chk("b2b_pass_clr", 32'(p0), 0);
    chk("b2b_cyc",  32'(c),    8);
    chk("b2b_pass", 32'(pass), 1);
    repeat (2) @(posedge clk);
    #1;

    // dataflow wired as a & ~b
    mode = 1;
    sweep(0, c, p0);
`ifdef F5_STOP_ON_MISMATCH_EN
    chk("bad_cyc",  32'(c),  4);
    chk("bad_ecnt", 32'(ec), 1);
`else
    chk("bad_cyc",  32'(c),  8);
    chk("bad_ecnt", 32'(ec), 2);
`endif
    chk("bad_eidx", 32'(ei),   1);
    chk("bad_pass", 32'(pass), 0);
    chk("bad_tt",   32'(tt),   4'b0010);
    mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // start re-pulsed mid-sweep is ignored
    sweep(3, c, p0);
    chk("rep_cyc", 32'(c), 8);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rep_extra_done", 32'(nd), 0);

    // reset mid-sweep discards partial results
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_vec",  32'(vec),  0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_pass", 32'(pass), 0);
    chk("mrst_tt",   32'(tt),   0);
    chk("mrst_eidx", 32'(ei),   0);
    chk("mrst_ecnt", 32'(ec),   0);
    sweep(0, c, p0);
    chk("mrst_cyc",  32'(c),    8);
    chk("mrst_ok",   32'(pass), 1);

    // SETTLE=3 instance: each vec held 4 cycles
    c = -1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("s3_vec0", 32'(vec3), 0);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done3) begin
        c = n;
        break;
      end
      chk($sformatf("s3_vec_c%0d", n), 32'(vec3), n / 4);
    end
    chk("s3_cyc",  32'(c),     16);
    chk("s3_tt",   32'(tt3),   4'b0010);
    chk("s3_pass", 32'(pass3), 1);
    chk("s3_ecnt", 32'(ec3),   0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/f5_sweep_ctrl.md
# f5_sweep_ctrl

Sweep controller for the two-input function f5 (s = ~a & b).
- Applies every input combination in turn to a gate-level and a dataflow implementation of f5.
- Waits a programmable settle time, samples both outputs, records the truth table of the gate-level reference, and counts mismatches against the dataflow version.
- Sits between the f5 implementations and the bench/top level, replacing hand-written `#1` stimulus with a clocked, self-checking sequencer.

## Interface
Parameters:
- N_IN, default 2: number of f5 inputs swept. Legal range 1..4.
- SETTLE, default 1: cycles each vector is held before sampling. Minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, synchronous and active-high.
- start  input  1  begin a sweep; sampled only in IDLE.
- s_ref  input  1  output of the gate-level f5 implementation.
- s_dut  input  1  output of the dataflow f5 implementation.
- vec  output  N_IN  input vector driven to both implementations. {a,b} = vec[1:0].
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep ends.
- pass  output  1  1 when the last sweep had zero mismatches. Valid from done until the next start.
- tt  output  2**N_IN  captured s_ref; bit i is the result for vec = i.
- err_idx  output  N_IN  index of the first mismatch; 0 if none.
- err_cnt  output  N_IN+1  number of mismatching vectors.

## Operation
- Reset values: vec=0, busy=0, done=0, pass=0, tt=0, err_idx=0, err_cnt=0, state IDLE.
- IDLE
  - start=1: vec<=0; tt, err_cnt, err_idx and pass cleared; wait counter<=SETTLE-1; go to SETTLE.
- SETTLE
  - vec held.
  - Counter decrements; at 0 go to SAMPLE.
- SAMPLE (one cycle)
  - tt[vec] <= s_ref.
  - If s_ref != s_dut: err_cnt increments, and err_idx <= vec when err_cnt == 0.
  - If vec == 2**N_IN-1, go to DONE. Otherwise vec increments, the counter reloads, and the state returns to SETTLE.
- DONE (one cycle)
  - done=1; pass <= (err_cnt == 0); go to IDLE.
  - vec stays at its last value until the next start.
- start while busy or in DONE is ignored; it is not queued.
- err_cnt width N_IN+1 holds the full range 0..2**N_IN without wrap.
- Reset mid-sweep: on the next edge all outputs take their reset values and the partial results are discarded.
- reset and start high together: reset wins.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles settling plus 1 cycle of SAMPLE.
- done is high in the cycle beginning 2**N_IN*(SETTLE+1) edges after the edge that captured start. With defaults this is 8.
- busy rises on the edge after start and falls on the edge entering DONE.
- tt, err_idx, err_cnt and pass are stable from the done cycle until the next accepted start.
- A start asserted in the cycle after done (state IDLE) is accepted. Back-to-back sweeps have one idle cycle between them.

## Configuration
- Macro F5_STOP_ON_MISMATCH_EN.
- Defined:
  - The first mismatching SAMPLE goes straight to DONE.
  - err_cnt is at most 1, and tt bits for unsampled vectors stay 0.
  - done arrives early, at (k+1)*(SETTLE+1) cycles, where k is the first failing index.
- Undefined: every sweep covers all 2**N_IN vectors.

## Test plan
- Correct implementations, default parameters, start pulsed: done at cycle 8, tt=4'b0010, pass=1, err_cnt=0, err_idx=0.
- s_dut wired to a & ~b:
  - Macro undefined: err_cnt=2, err_idx=1, pass=0, tt=4'b0010, done at cycle 8.
  - Macro defined: done at cycle 4, err_cnt=1, err_idx=1, tt=4'b0010.
- start re-pulsed at cycle 3 of a sweep: ignored; exactly one done pulse, at cycle 8.
- reset asserted at cycle 5 mid-sweep: next cycle all outputs 0 and busy=0. A following start completes normally with done 8 cycles later.
- SETTLE=3: each vec value is held 4 cycles, vec sequence is 0,1,2,3, done at cycle 16.
- start in the cycle right after done: new sweep accepted, pass cleared on that edge, second done 8 cycles later.
